serial_alu_responder: RTL and testbench

//   Multi-cycle add/sub ALU that answers the control unit's alu_start/alu_done request.

---
 rtl/serial_alu_responder_if.sv | 28 ++
 rtl/serial_alu_responder.sv | 143 ++++++++++++++
 tb/tb_serial_alu_responder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_alu_responder_if.sv
// Request/response bundle between the control unit (master) and the serial ALU (slave).
// The register file drives the operand lines on the master side.
interface serial_alu_responder_if #(
    parameter int WIDTH = 16
);
    logic             alu_start;
    logic             alu_op;
    logic             immediate;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic [WIDTH-1:0] sgnext_imm;
    logic [WIDTH-1:0] alu_result;
    logic             alu_done;
    logic             alu_busy;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output alu_start, alu_op, immediate, rs1_data, rs2_data, sgnext_imm,
        input  alu_result, alu_done, alu_busy, flag_z, flag_c, flag_v
    );

    modport slave (
        input  alu_start, alu_op, immediate, rs1_data, rs2_data, sgnext_imm,
        output alu_result, alu_done, alu_busy, flag_z, flag_c, flag_v
    );
endinterface

// File: rtl/serial_alu_responder.sv
// Digit-serial add/sub ALU with a four-phase alu_start/alu_done handshake.
// Operands are latched at the request, then DIGIT bits are summed per cycle, LSB first.
module serial_alu_responder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_alu_responder_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_v_q, flag_v_d;

    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] b_eff;
    logic [DIGIT:0]   slice_sum;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        result_d  = result_q;
        carry_d   = carry_q;
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        done_d    = done_q;
        busy_d    = busy_q;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
        flag_v_d  = flag_v_q;

        b_sel     = bus.immediate ? bus.sgnext_imm : bus.rs2_data;
        b_eff     = bus.alu_op ? ~b_sel : b_sel;
        slice_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};

        case (state_q)
            IDLE: begin
                if (bus.alu_start) begin
                    a_d     = bus.rs1_data;
                    b_d     = b_eff;
                    a_msb_d = bus.rs1_data[WIDTH-1];
                    b_msb_d = b_eff[WIDTH-1];
                    carry_d = bus.alu_op;
                    count_d = '0;
                    sum_d   = '0;
                    busy_d  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Operands shift down so the active slice is always at bit 0; sums enter at the top.
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                sum_d   = (sum_q >> DIGIT) | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
                carry_d = slice_sum[DIGIT];
                count_d = count_q + CW'(1);
                if (count_q == CW'(N - 1)) begin
                    result_d = sum_d;
                    flag_c_d = slice_sum[DIGIT];
                    flag_v_d = (a_msb_q == b_msb_q) && (sum_d[WIDTH-1] != a_msb_q);
                    flag_z_d = (sum_d == '0);
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    count_d  = '0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (!bus.alu_start) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
            flag_v_q <= flag_v_d;
        end
    end

    assign bus.alu_result = result_q;
    assign bus.alu_done   = done_q;
    assign bus.alu_busy   = busy_q;
    assign bus.flag_z     = flag_z_q;
    assign bus.flag_c     = flag_c_q;
    assign bus.flag_v     = flag_v_q;
endmodule

// File: tb/tb_serial_alu_responder.sv
// Scoreboard bench for serial_alu_responder: the driver queues hand-computed results,
// a monitor pops and compares them on every rising alu_done.
module tb_serial_alu_responder;
    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int N     = WIDTH / DIGIT;

    logic clk = 1'b0;
    logic reset;

    serial_alu_responder_if #(.WIDTH(WIDTH)) bus ();

    serial_alu_responder #(
        .WIDTH(WIDTH),
        .DIGIT(DIGIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] result;
        logic [2:0]  zcv;
        int          done_edge;
    } exp_t;

    exp_t sb_q[$];
    int   n_compared = 0;
    int   n_failed   = 0;
    int   edge_count = 0;

    always @(posedge clk) edge_count++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every rising alu_done must match the oldest queued expectation, including its latency
    initial begin
        logic done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                done_prev = 1'b0;
            end else begin
                if (bus.alu_done && !done_prev) begin
                    if (sb_q.size() == 0) begin
                        checkOutput("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        checkOutput({e.name, "_result"}, 32'(bus.alu_result), 32'(e.result));
                        checkOutput({e.name, "_zcv"}, 32'({bus.flag_z, bus.flag_c, bus.flag_v}), 32'(e.zcv));
                        checkOutput({e.name, "_latency"}, 32'(edge_count), 32'(e.done_edge));
                    end
                end
                done_prev = bus.alu_done;
            end
        end
    end

    task automatic applyStimulus(
        input string       name,
        input bit          op,
        input bit          imm,
        input logic [15:0] rs1,
        input logic [15:0] rs2,
        input logic [15:0] immv,
        input logic [15:0] exp_result,
        input logic [2:0]  exp_zcv,
        input int          hold,
        input bit          scramble
    );
        exp_t e;
        int   waited;
        @(negedge clk);
        bus.alu_op     = op;
        bus.immediate  = imm;
        bus.rs1_data   = rs1;
        bus.rs2_data   = rs2;
        bus.sgnext_imm = immv;
        bus.alu_start  = 1'b1;
        e.name      = name;
        e.result    = exp_result;
        e.zcv       = exp_zcv;
        e.done_edge = edge_count + 1 + N;
        sb_q.push_back(e);

        @(negedge clk);
        checkOutput({name, "_busy"}, 32'(bus.alu_busy), 32'd1);
        checkOutput({name, "_early_done"}, 32'(bus.alu_done), 32'd0);

        waited = 0;
        while (!bus.alu_done && waited < 20) begin
            if (scramble) begin
                bus.rs1_data   = 16'($urandom);
                bus.rs2_data   = 16'($urandom);
                bus.sgnext_imm = 16'($urandom);
                bus.alu_op     = ~bus.alu_op;
            end
            @(negedge clk);
            waited++;
        end
        if (!bus.alu_done) begin
            checkOutput({name, "_timeout"}, 32'd0, 32'd1);
            bus.alu_start = 1'b0;
            @(negedge clk);
            return;
        end

        // Start held high in DONE: no new op may begin, result must not move
        for (int i = 0; i < hold; i++) begin
            if (scramble) begin
                bus.rs1_data = 16'($urandom);
                bus.rs2_data = 16'($urandom);
                bus.alu_op   = ~bus.alu_op;
            end
            @(negedge clk);
            checkOutput({name, "_hold_done"}, 32'(bus.alu_done), 32'd1);
            checkOutput({name, "_hold_busy"}, 32'(bus.alu_busy), 32'd0);
            checkOutput({name, "_hold_result"}, 32'(bus.alu_result), 32'(exp_result));
        end

        bus.alu_start = 1'b0;
        @(negedge clk);
        checkOutput({name, "_done_drop"}, 32'(bus.alu_done), 32'd0);
        checkOutput({name, "_idle_result"}, 32'(bus.alu_result), 32'(exp_result));
    endtask

    initial begin
        reset          = 1'b0;
        bus.alu_start  = 1'b0;
        bus.alu_op     = 1'b0;
        bus.immediate  = 1'b0;
        bus.rs1_data   = '0;
        bus.rs2_data   = '0;
        bus.sgnext_imm = '0;
        #1 reset = 1'b1;
        #1;
        checkOutput("reset_done", 32'(bus.alu_done), 32'd0);
        checkOutput("reset_busy", 32'(bus.alu_busy), 32'd0);
        checkOutput("reset_result", 32'(bus.alu_result), 32'd0);
        checkOutput("reset_zcv", 32'({bus.flag_z, bus.flag_c, bus.flag_v}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        //             name         op    imm   rs1       rs2       imm       result    zcv     hold scr
        applyStimulus("add_basic",  1'b0, 1'b0, 16'h1234, 16'h0F0F, 16'h0000, 16'h2143, 3'b000, 0, 1'b0);
        applyStimulus("sub_zero",   1'b1, 1'b0, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 3'b110, 0, 1'b0);
        applyStimulus("sub_borrow", 1'b1, 1'b0, 16'h0003, 16'h0005, 16'h0000, 16'hFFFE, 3'b000, 0, 1'b0);
        applyStimulus("add_ovf",    1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000, 3'b001, 0, 1'b0);
        applyStimulus("add_wrap",   1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 3'b110, 0, 1'b0);
        applyStimulus("add_imm",    1'b0, 1'b1, 16'h0010, 16'h1111, 16'hFFFE, 16'h000E, 3'b010, 0, 1'b0);
        applyStimulus("sub_scramb", 1'b1, 1'b0, 16'h4321, 16'h1111, 16'h0000, 16'h3210, 3'b010, 3, 1'b1);
        applyStimulus("add_carry",  1'b0, 1'b0, 16'hFFFF, 16'h0002, 16'h0000, 16'h0001, 3'b010, 0, 1'b0);

        // Abort an op mid-flight at count=2; nothing is queued for it
        @(negedge clk);
        bus.alu_op    = 1'b0;
        bus.immediate = 1'b0;
        bus.rs1_data  = 16'h1234;
        bus.rs2_data  = 16'h1111;
        bus.alu_start = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("abort_busy_before", 32'(bus.alu_busy), 32'd1);
        #1;
        reset         = 1'b1;
        bus.alu_start = 1'b0;
        #1;
        checkOutput("abort_done", 32'(bus.alu_done), 32'd0);
        checkOutput("abort_busy", 32'(bus.alu_busy), 32'd0);
        checkOutput("abort_result", 32'(bus.alu_result), 32'd0);
        checkOutput("abort_zcv", 32'({bus.flag_z, bus.flag_c, bus.flag_v}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus("sub_ovf",    1'b1, 1'b0, 16'h8000, 16'h0001, 16'h0000, 16'h7FFF, 3'b011, 0, 1'b0);
        applyStimulus("sub_neg1",   1'b1, 1'b1, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h8000, 3'b001, 1, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, compared=%0d", n_compared);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
